// File: rtl/sync_tx_arbiter.sv
// sync_tx_arbiter: round-robin sharing of one enable-qualified crossing, sequencing setup/hold/gap per word
module sync_tx_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic                         busy
);
  localparam int CMAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int PW   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_ptr;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [PW-1:0]        w_off, w_win, w_ptr_nxt;
  logic [PW:0]          w_sum;
  logic [NUM_REQ-1:0]   w_onehot;
  logic [BUS_WIDTH-1:0] w_data;
  // rotate requests so the pointer sits at bit 0; lowest set bit is the winner's offset
  always_comb begin
    w_dbl = {req, req} >> r_ptr;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_dbl[k]) w_off = PW'(k);
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_win     = w_sum >= (PW+1)'(NUM_REQ) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : PW'(w_sum);
    w_ptr_nxt = w_win == PW'(NUM_REQ - 1) ? '0 : w_win + 1'b1;
    w_onehot  = NUM_REQ'(1) << w_win;
    w_data    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_data = w_data | (w_onehot[i] ? req_data[i*BUS_WIDTH +: BUS_WIDTH] : '0);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      ack        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack <= '0;
      case (r_state)
        IDLE: if (|req) begin
          unsync_bus <= w_data;
          ack        <= w_onehot;
          r_ptr      <= w_ptr_nxt;
          busy       <= 1'b1;
          r_state    <= SETUP;
        end
        SETUP: begin
          bus_enable <= 1'b1;
          r_cnt      <= CW'(HOLD_CYCLES - 1);
          r_state    <= HOLD;
        end
        HOLD: if (r_cnt == '0) begin
          bus_enable <= 1'b0;
          r_cnt      <= CW'(GAP_CYCLES - 1);
          r_state    <= GAP;
        end else r_cnt <= r_cnt - 1'b1;
        GAP: if (r_cnt == '0) begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end else r_cnt <= r_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_tx_arbiter.sv
// tb_sync_tx_arbiter: table-driven trace plus scoreboard of expected grants for sync_tx_arbiter
module tb_sync_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [3:0] req, req6, ack, ack6;
  logic [31:0] data, data6;
  logic [7:0] bus, bus6, pbus, pbus6;
  logic en, en6, busy, busy6, pen, pen6;
  sync_tx_arbiter dut (
    .CLK(clk), .RST(rst), .req(req), .req_data(data), .ack(ack),
    .unsync_bus(bus), .bus_enable(en), .busy(busy)
  );
  sync_tx_arbiter #(.HOLD_CYCLES(1), .GAP_CYCLES(5)) dut6 (
    .CLK(clk), .RST(rst), .req(req6), .req_data(data6), .ack(ack6),
    .unsync_bus(bus6), .bus_enable(en6), .busy(busy6)
  );
  typedef struct {logic [1:0] idx; logic [7:0] data;} exp_t;
  typedef struct {logic [3:0] req; logic [3:0] ack; logic [7:0] bus; logic en; logic busy;} vec_t;
  exp_t q[$];
  int acks[$];
  vec_t tv[10];
  int n_err = 0, n_chk = 0, cyc = 0;
  logic [3:0] drop;
  bit sb_on;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pen && en) chk("bus_stable", 32'(bus), 32'(pbus));
    if (pen6 && en6) chk("bus6_stable", 32'(bus6), 32'(pbus6));
    pen = en; pbus = bus; pen6 = en6; pbus6 = bus6;
    if (sb_on && ack != 4'b0) begin
      acks.push_back(cyc);
      if (q.size() == 0) chk("sb_unexpected_ack", 32'(ack), 32'h0);
      else begin
        e = q.pop_front();
        chk("sb_ack", 32'(ack), 32'(4'b0001 << e.idx));
        chk("sb_bus", 32'(bus), 32'(e.data));
      end
    end
    req = req & ~(ack & drop);
  endtask
  task automatic push(input logic [1:0] idx, input logic [7:0] d);
    exp_t e;
    e.idx = idx;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic wait_sb(input int budget);
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("sb_drained", 32'(q.size()), 32'h0);
    q.delete();
  endtask
  task automatic wait_idle(input int budget);
    while ((busy || busy6) && budget > 0) begin
      tick();
      budget--;
    end
    chk("idle", 32'({busy, busy6}), 32'h0);
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; req6 = '0; drop = '0;
    tick();
    tick();
    rst = 1'b0; pen = 1'b0; pen6 = 1'b0;
    q.delete();
    acks.delete();
  endtask
  initial begin
    logic [8:0] e_en6, e_ack6, e_busy6;
    int b;
    rst = 1'b1; req = '0; req6 = '0; data = '0; data6 = '0; drop = '0; sb_on = 1'b0;
    pen = 1'b0; pen6 = 1'b0; pbus = '0; pbus6 = '0;
    tv[0] = '{4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1};
    tv[1] = '{4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tv[2] = '{4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tv[3] = '{4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tv[4] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1};
    tv[5] = '{4'b0010, 4'b0000, 8'hA5, 1'b0, 1'b1};
    tv[6] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1};
    tv[7] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};
    tv[8] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};
    tv[9] = '{4'b0010, 4'b0010, 8'h5B, 1'b0, 1'b1};
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_bus", 32'(bus), 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_en6", 32'({ack6, en6, busy6}), 32'h0);
    rst = 1'b0;
    // single transfer trace; a request raised during GAP is ignored until it is still high in IDLE
    data = 32'h0000_5BA5;
    foreach (tv[i]) begin
      req = tv[i].req;
      tick();
      chk($sformatf("t1[%0d].ack", i), 32'(ack), 32'(tv[i].ack));
      chk($sformatf("t1[%0d].bus", i), 32'(bus), 32'(tv[i].bus));
      chk($sformatf("t1[%0d].en", i), 32'(en), 32'(tv[i].en));
      chk($sformatf("t1[%0d].busy", i), 32'(busy), 32'(tv[i].busy));
    end
    req = '0;
    wait_idle(20);
    // all four request at once
    do_reset();
    sb_on = 1'b1;
    data = 32'h1312_1110;
    drop = 4'hF;
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12); push(2'd3, 8'h13);
    req = 4'hF;
    wait_sb(40);
    chk("t2_nacks", 32'(acks.size()), 32'd4);
    if (acks.size() >= 4)
      for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(acks[i] - acks[i-1]), 32'd8);
    wait_idle(20);
    // fairness: req0 held permanently, req2 joins after the first grant
    do_reset();
    data = 32'h0032_0030;
    push(2'd0, 8'h30); push(2'd2, 8'h32); push(2'd0, 8'h30); push(2'd2, 8'h32);
    req = 4'b0001;
    b = 0;
    while (q.size() > 3 && b < 20) begin
      tick();
      b++;
    end
    req[2] = 1'b1;
    wait_sb(40);
    req = '0;
    wait_idle(20);
    // pointer wrap after a grant to 3
    do_reset();
    data = 32'h4342_4140;
    drop = 4'hF;
    push(2'd3, 8'h43);
    req = 4'b1000;
    wait_sb(20);
    wait_idle(20);
    drop = 4'h0;
    push(2'd1, 8'h41); push(2'd3, 8'h43);
    req = 4'b1010;
    wait_sb(40);
    req = '0;
    wait_idle(20);
    // reset on the second HOLD cycle aborts and clears the pointer
    do_reset();
    data = 32'h0066_0055;
    drop = 4'hF;
    push(2'd0, 8'h55);
    req = 4'b0001;
    wait_sb(20);
    tick();
    chk("t5_hold1_en", 32'(en), 32'h1);
    tick();
    chk("t5_hold2_en", 32'(en), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_en", 32'(en), 32'h0);
    chk("t5_rst_bus", 32'(bus), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_ack", 32'(ack), 32'h0);
    push(2'd0, 8'h55); push(2'd2, 8'h66);
    req = 4'b0101;
    wait_sb(40);
    wait_idle(20);
    // HOLD_CYCLES=1, GAP_CYCLES=5 instance: one enable cycle, five low, period 8
    do_reset();
    sb_on = 1'b0;
    data6 = 32'h0000_00C6;
    e_en6 = 9'b000000010;
    e_ack6 = 9'b100000001;
    e_busy6 = 9'b101111111;
    req6 = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t6[%0d].ack", i), 32'(ack6), 32'(e_ack6[i]));
      chk($sformatf("t6[%0d].en", i), 32'(en6), 32'(e_en6[i]));
      chk($sformatf("t6[%0d].busy", i), 32'(busy6), 32'(e_busy6[i]));
      chk($sformatf("t6[%0d].bus", i), 32'(bus6), 32'hC6);
    end
    req6 = '0;
    wait_idle(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
